reset_sequencer: RTL and testbench

- Parametrised successor to the fixed 16-cycle, two-source reset stretcher in the MiST top level.
- Takes N synchronous reset-request sources, each edge-qualified on rising or falling edge, plus a PLL lock input.
- Produces a stretched reset pulse, then releases M reset domains in staggered order (e.g. dbl, bus, cpu).
- Adds lock-loss handling, an optional hold-after-power-on mode (the debug "perma reset") and a latched reset-cause vector.

---
 rtl/reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_reset_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: edge-qualified reset requests and PLL lock gate a stretched
// reset, after which the domain resets are released one at a time in index order.
module reset_sequencer #(
    parameter int                 NUM_SRC        = 2,
    parameter logic [NUM_SRC-1:0] SRC_NEGEDGE    = NUM_SRC'(2'b01),
    parameter int                 STRETCH_CYCLES = 16,
    parameter int                 NUM_DOMAINS    = 3,
    parameter int                 STAGE_GAP      = 4,
    parameter bit                 HOLD_AT_POR    = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src,
    input  logic                   locked,
    input  logic                   release_btn,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic [NUM_SRC:0]       cause
);

    localparam int CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_LOCK_WAIT,
        S_STRETCH,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 r_state;
    logic [NUM_SRC-1:0]     r_prev_src;
    logic                   r_prev_btn;
    logic                   r_lock_meta;
    logic                   r_lock_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic [GAP_W-1:0]       r_gap;
    logic [NUM_DOMAINS-1:0] r_rst_out;
    logic                   r_busy;
    logic [NUM_SRC:0]       r_cause;

    logic [NUM_SRC-1:0]     w_event;
    logic                   w_any_event;
    logic                   w_btn_rise;
    logic [NUM_SRC:0]       w_cause_ev;
    logic [NUM_DOMAINS-1:0] w_rst_shift;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_edge
            assign w_event[gi] = SRC_NEGEDGE[gi] ? (r_prev_src[gi] & ~src[gi])
                                                 : (src[gi] & ~r_prev_src[gi]);
        end
    endgenerate

    assign w_any_event = |w_event;
    assign w_btn_rise  = release_btn & ~r_prev_btn;
    // Top bit flags lock loss; it is only ever 1 when the lock-loss branch is taken.
    assign w_cause_ev  = {~r_lock_sync, w_event};
    // Releasing domains in index order is a left shift of the asserted mask.
    assign w_rst_shift = r_rst_out << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD_AT_POR ? S_HOLD : S_LOCK_WAIT;
            r_prev_src  <= src;
            r_prev_btn  <= release_btn;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_rst_out   <= '1;
            r_busy      <= 1'b1;
            r_cause     <= '0;
        end else begin
            r_prev_src  <= src;
            r_prev_btn  <= release_btn;
            r_lock_meta <= locked;
            r_lock_sync <= r_lock_meta;
            case (r_state)
                S_HOLD: begin
                    if (w_btn_rise) begin
                        r_state <= S_LOCK_WAIT;
                    end
                end
                S_LOCK_WAIT: begin
                    if (r_lock_sync) begin
                        r_state <= S_STRETCH;
                        r_cnt   <= '0;
                    end
                end
                S_STRETCH, S_RELEASE, S_RUN: begin
                    // Lock loss outranks a simultaneous event; both land in cause.
                    if (!r_lock_sync || w_any_event) begin
                        r_state   <= r_lock_sync ? S_STRETCH : S_LOCK_WAIT;
                        r_cnt     <= '0;
                        r_gap     <= '0;
                        r_rst_out <= '1;
                        r_busy    <= 1'b1;
                        r_cause   <= (r_state == S_RUN) ? w_cause_ev : (r_cause | w_cause_ev);
                    end else if (r_state == S_STRETCH) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_cnt     <= '0;
                            r_gap     <= '0;
                            r_rst_out <= w_rst_shift;
                            if (w_rst_shift == '0) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_RELEASE;
                            end
                        end
                    end else if (r_state == S_RELEASE) begin
                        r_gap <= r_gap + GAP_W'(1);
                        if (r_gap == GAP_LAST) begin
                            r_gap     <= '0;
                            r_rst_out <= w_rst_shift;
                            if (w_rst_shift == '0) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= S_LOCK_WAIT;
                    r_rst_out <= '1;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign busy    = r_busy;
    assign cause   = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (default, hold-at-POR, single domain)
// share one stimulus script; a timeline model predicts outputs every cycle.
module tb_reset_sequencer;

    localparam int STR = 16;
    localparam int GAP = 4;
    localparam logic [1:0] NEG = 2'b01;
    localparam int DOM [3] = '{3, 3, 1};
    localparam int HLD [3] = '{0, 1, 0};

    logic       clk;
    logic       reset;
    logic [1:0] src;
    logic       locked;
    logic       release_btn;

    logic [2:0] rst_a, rst_h;
    logic [0:0] rst_o;
    logic       busy_a, busy_h, busy_o;
    logic [2:0] cause_a, cause_h, cause_o;

    reset_sequencer u_dut (
        .clk(clk), .reset(reset), .src(src), .locked(locked), .release_btn(release_btn),
        .rst_out(rst_a), .busy(busy_a), .cause(cause_a)
    );

    reset_sequencer #(.HOLD_AT_POR(1'b1)) u_hold (
        .clk(clk), .reset(reset), .src(src), .locked(locked), .release_btn(release_btn),
        .rst_out(rst_h), .busy(busy_h), .cause(cause_h)
    );

    reset_sequencer #(.NUM_DOMAINS(1)) u_one (
        .clk(clk), .reset(reset), .src(src), .locked(locked), .release_btn(release_btn),
        .rst_out(rst_o), .busy(busy_o), .cause(cause_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int t0 = 3;

    // Model: mode 0 = held, 1 = waiting for lock, 2 = sequencing since m_start.
    int         m_mode  [3];
    int         m_start [3];
    logic [2:0] m_cause [3];
    logic [1:0] m_prev_src;
    logic       m_prev_btn;
    logic       m_lk1, m_lk2;

    always @(posedge clk) begin
        logic [1:0] ev;
        logic       seen;
        logic       rise;
        logic       in_run;
        edge_n = edge_n + 1;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_mode[k]  = (HLD[k] != 0) ? 0 : 1;
                m_start[k] = 0;
                m_cause[k] = 3'b000;
            end
            m_lk1 = 1'b0;
            m_lk2 = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                ev[i] = NEG[i] ? (m_prev_src[i] & ~src[i]) : (src[i] & ~m_prev_src[i]);
            seen = m_lk2;
            rise = release_btn & ~m_prev_btn;
            for (int k = 0; k < 3; k++) begin
                if (m_mode[k] == 0) begin
                    if (rise) m_mode[k] = 1;
                end else if (m_mode[k] == 1) begin
                    if (seen) begin
                        m_mode[k]  = 2;
                        m_start[k] = edge_n;
                    end
                end else begin
                    in_run = (edge_n - m_start[k]) > (STR + GAP * (DOM[k] - 1));
                    if (!seen) begin
                        m_mode[k]  = 1;
                        m_cause[k] = in_run ? {1'b1, ev} : (m_cause[k] | {1'b1, ev});
                    end else if (ev != 2'b00) begin
                        m_start[k] = edge_n;
                        m_cause[k] = in_run ? {1'b0, ev} : (m_cause[k] | {1'b0, ev});
                    end
                end
            end
            m_lk2 = m_lk1;
            m_lk1 = locked;
        end
        m_prev_src = src;
        m_prev_btn = release_btn;
    end

    function automatic logic [2:0] exp_rst(input int k);
        logic [2:0] r;
        r = 3'b000;
        for (int d = 0; d < DOM[k]; d++)
            r[d] = (m_mode[k] != 2) || ((edge_n - m_start[k]) < (STR + GAP * d));
        return r;
    endfunction

    function automatic logic exp_busy(input int k);
        return (m_mode[k] != 2) || ((edge_n - m_start[k]) < (STR + GAP * (DOM[k] - 1)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n - t0, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [2:0] r, input logic b, input logic [2:0] c);
        check($sformatf("model rst_out u%0d", k), 32'(r), 32'(exp_rst(k)));
        check($sformatf("model busy u%0d", k), 32'(b), 32'(exp_busy(k)));
        check($sformatf("model cause u%0d", k), 32'(c), 32'(m_cause[k]));
    endtask

    always @(negedge clk) begin
        if (edge_n >= 1) begin
            cmp_inst(0, rst_a, busy_a, cause_a);
            cmp_inst(1, rst_h, busy_h, cause_h);
            cmp_inst(2, {2'b00, rst_o}, busy_o, cause_o);
        end
    end

    task automatic at(input int k);
        while (edge_n < t0 + k) @(negedge clk);
    endtask

    task automatic note(input string msg);
        $display("edge %0d: %s", edge_n - t0, msg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        src = 2'b11;
        locked = 1'b1;
        release_btn = 1'b0;

        at(0);  reset = 1'b0; note("reset released, src held high");
        at(18); check("por rst@18", 32'(rst_a), 32'h7);
                check("por one busy@18", 32'(busy_o), 32'h1);
        at(19); check("por rst@19", 32'(rst_a), 32'h6);
                check("por one rst@19", 32'(rst_o), 32'h0);
                check("por one busy@19", 32'(busy_o), 32'h0);
        at(23); check("por rst@23", 32'(rst_a), 32'h4);
        at(26); check("por busy@26", 32'(busy_a), 32'h1);
        at(27); check("por rst@27", 32'(rst_a), 32'h0);
                check("por busy@27", 32'(busy_a), 32'h0);
                check("por cause@27", 32'(cause_a), 32'h0);
                check("hold rst@27", 32'(rst_h), 32'h7);

        at(34); src = 2'b01; note("src1 falls (no trigger)");
        at(39); src = 2'b11; note("src1 rises");
        at(40); check("src1 rst@E", 32'(rst_a), 32'h7);
                check("src1 cause@E", 32'(cause_a), 32'h2);
        at(55); check("src1 rst@E+15", 32'(rst_a), 32'h7);
        at(56); check("src1 rst@E+16", 32'(rst_a), 32'h6);
        at(57); src = 2'b10; note("src0 falls during RELEASE");
        at(58); check("retrig rst", 32'(rst_a), 32'h7);
                check("retrig cause", 32'(cause_a), 32'h3);
        at(73); check("retrig rst@+15", 32'(rst_a), 32'h7);
        at(74); check("retrig rst@+16", 32'(rst_a), 32'h6);
        at(82); check("retrig rst@+24", 32'(rst_a), 32'h0);
                check("retrig busy@+24", 32'(busy_a), 32'h0);

        at(89); src = 2'b11; note("src0 rises (no trigger)");
        at(94); src = 2'b10; note("src0 falls in RUN");
        at(95); check("src0 cause", 32'(cause_a), 32'h1);
                check("src0 rst", 32'(rst_a), 32'h7);
        at(100); check("hold rst@100", 32'(rst_h), 32'h7);
                 check("hold busy@100", 32'(busy_h), 32'h1);
        at(119); check("src0 rst@+24", 32'(rst_a), 32'h0);

        at(129); locked = 1'b0; note("lock lost");
        at(131); check("lock rst@+1", 32'(rst_a), 32'h0);
        at(132); check("lock rst@+2", 32'(rst_a), 32'h7);
                 check("lock cause", 32'(cause_a), 32'h4);
        at(134); locked = 1'b1; note("lock regained");
        at(152); check("relock rst@152", 32'(rst_a), 32'h7);
        at(153); check("relock rst@153", 32'(rst_a), 32'h6);
        at(161); check("relock rst@161", 32'(rst_a), 32'h0);

        at(165); src = 2'b01; note("src swap (no trigger)");
        at(169); locked = 1'b0; note("lock lost again");
        at(171); src = 2'b11; note("src1 rises with lock loss");
        at(172); check("both cause", 32'(cause_a), 32'h6);
                 check("both rst", 32'(rst_a), 32'h7);
        at(174); locked = 1'b1; note("lock regained");
        at(201); check("both rst@201", 32'(rst_a), 32'h0);

        at(204); release_btn = 1'b1; note("release_btn rises");
        at(221); check("hold rst@B+16", 32'(rst_h), 32'h7);
        at(222); check("hold rst@B+17", 32'(rst_h), 32'h6);
        at(230); check("hold rst@B+25", 32'(rst_h), 32'h0);
                 check("hold busy@B+25", 32'(busy_h), 32'h0);

        at(239); src = 2'b10; note("src0 falls");
        at(258); reset = 1'b1; note("reset pulsed during RELEASE");
        at(259); check("rpulse rst", 32'(rst_a), 32'h7);
                 check("rpulse cause", 32'(cause_a), 32'h0);
                 check("rpulse busy", 32'(busy_a), 32'h1);
                 reset = 1'b0;
        at(286); check("rpulse rst@+27", 32'(rst_a), 32'h0);
                 check("rpulse hold rst", 32'(rst_h), 32'h7);
        at(300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
